pc_fetch_controller: RTL and testbench

Sequences the program counter datapath. It owns pc_current and pc_next, issues instruction-memory fetches over a valid/ready handshake, and holds each fetched instruction until decode accepts it. It applies branch/jump redirects and a load-use/hazard stall. It sits between the PC register path and the decode stage of the single-issue RISC-V core.

---
 rtl/pc_ctrl_pkg.sv | 20 ++
 rtl/pc_next_mux.sv | 31 +++
 rtl/pc_fetch_controller.sv | 157 +++++++++++++++
 tb/tb_pc_fetch_controller.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the fetch controller.
// State encoding, instruction size and alignment helpers.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_e;

    localparam int         INSTR_BYTES = 4;
    localparam logic [1:0] ALIGN_MASK  = 2'b11;

    // True when the low address bits break 4-byte alignment.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return (lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC select: sequential, redirect, or trap on bad target.
// Also flags a misaligned redirect target.
module pc_next_mux
    import pc_ctrl_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h0000_0010)
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_target,
    output logic [XLEN-1:0] o_pc_next,
    output logic            o_misaligned
);

    logic [XLEN-1:0] w_pc_seq;

    // Wraps naturally at the top of the address space.
    assign w_pc_seq = i_pc + XLEN'(INSTR_BYTES);

    // Redirect wins over sequential; bad targets go to the trap vector.
    always_comb begin
        o_misaligned = i_redirect_valid
                    && is_misaligned(i_redirect_target[1:0]);
        o_pc_next    = w_pc_seq;
        if (i_redirect_valid) begin
            o_pc_next = o_misaligned ? TRAP_VECTOR : i_redirect_target;
        end
    end

endmodule

// File: rtl/pc_fetch_controller.sv
// PC sequencing and single-outstanding instruction fetch.
// Holds each fetched word until decode accepts it.
module pc_fetch_controller
    import pc_ctrl_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0010)
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            stall,
    output logic [XLEN-1:0] pc_current,
    output logic [XLEN-1:0] pc_next,
    output logic            misaligned_fault
);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_instr_data;
    logic [XLEN-1:0] r_instr_pc;
    logic            r_kill;

    logic [XLEN-1:0] w_pc_next;
    logic            w_mis;
    logic            w_redirect;
    logic            w_req_hs;
    logic            w_resp_take;

    pc_next_mux #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_pc_next_mux (
        .i_pc              (r_pc),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .o_pc_next         (w_pc_next),
        .o_misaligned      (w_mis)
    );

    // Redirects are ignored during the boot bubble.
    assign w_redirect  = redirect_valid && (r_state != BOOT);
    assign w_req_hs    = imem_req_valid && imem_req_ready;
    assign w_resp_take = (r_state == WAIT) && imem_resp_valid
                      && !redirect_valid && !r_kill;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: redirect beats stall and decode acceptance.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            BOOT: w_state_nxt = REQ;
            REQ: begin
                if (w_req_hs) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    w_state_nxt = (redirect_valid || r_kill) ? REQ : HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid || instr_ready) begin
                    w_state_nxt = REQ;
                end
            end
        endcase
    end

    // Outputs: request only in REQ, held word masked by a redirect.
    always_comb begin
        imem_req_valid = 1'b0;
        instr_valid    = 1'b0;
        unique case (r_state)
            BOOT: ;
            REQ:  imem_req_valid = !stall && !redirect_valid;
            WAIT: ;
            HOLD: instr_valid = !redirect_valid;
        endcase
    end

    // PC, fetch address capture and held instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc         <= RESET_VECTOR;
            r_fetch_pc   <= '0;
            r_instr_data <= '0;
            r_instr_pc   <= '0;
        end else begin
            if (w_redirect || w_req_hs) begin
                r_pc <= w_pc_next;
            end
            if (w_req_hs) begin
                r_fetch_pc <= r_pc;
            end
            if (w_resp_take) begin
                r_instr_data <= imem_resp_data;
                r_instr_pc   <= r_fetch_pc;
            end
        end
    end

    // Kill marks the in-flight response as stale after a redirect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_kill <= 1'b0;
        end else if (r_state == WAIT) begin
            if (imem_resp_valid) begin
                r_kill <= 1'b0;
            end else if (redirect_valid) begin
                r_kill <= 1'b1;
            end
        end
    end

    assign imem_req_addr    = r_pc;
    assign pc_current       = r_pc;
    assign pc_next          = w_pc_next;
    assign instr_data       = r_instr_data;
    assign instr_pc         = r_instr_pc;
    assign misaligned_fault = w_mis && (r_state != BOOT);

    // No request while a fetch is outstanding or being held.
    a_no_req_busy: assert property (
        @(posedge clk) disable iff (!reset_n)
        (r_state == WAIT || r_state == HOLD) |-> !imem_req_valid
    );

    // A request only leaves REQ with nothing in flight.
    a_one_outstanding: assert property (
        @(posedge clk) disable iff (!reset_n)
        imem_req_valid |-> (r_state == REQ && !r_kill)
    );

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Bench for pc_fetch_controller: directed scenarios plus a
// randomized run against a PC / instruction-stream model.
module tb_pc_fetch_controller;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        stall = 1'b0;
    logic [31:0] pc_current;
    logic [31:0] pc_next;
    logic        misaligned_fault;

    pc_fetch_controller #(
        .XLEN         (32),
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_data   (imem_resp_data),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr_data       (instr_data),
        .instr_pc         (instr_pc),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .stall            (stall),
        .pc_current       (pc_current),
        .pc_next          (pc_next),
        .misaligned_fault (misaligned_fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    // memory responder state
    bit          pend = 0;
    logic [31:0] pend_addr = '0;
    int          cnt = 0;
    int          dly_min = 1;
    int          dly_max = 1;
    bit          rdy_rand = 0;
    bit          stray_en = 0;

    // values observed just before the active edge
    logic        o_req_valid, o_hs, o_instr_valid, o_acc, o_fault, o_resp;
    logic [31:0] o_req_addr, o_pc_next, o_instr_pc, o_instr_data;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a << 3) ^ 32'h1357_9BDF ^ {a[7:0], 24'h0};
    endfunction

    // One clock: drive memory, sample before the edge, pass the edge.
    task automatic step();
        if (pend && cnt == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = instr_of(pend_addr);
        end else begin
            imem_resp_valid = stray_en && !pend && ($urandom_range(7) == 0);
            imem_resp_data  = $urandom;
        end
        if (rdy_rand) imem_req_ready = 1'($urandom_range(1));
        #1;
        o_req_valid   = imem_req_valid;
        o_req_addr    = imem_req_addr;
        o_hs          = imem_req_valid && imem_req_ready;
        o_instr_valid = instr_valid;
        o_acc         = instr_valid && instr_ready;
        o_instr_pc    = instr_pc;
        o_instr_data  = instr_data;
        o_pc_next     = pc_next;
        o_fault       = misaligned_fault;
        o_resp        = imem_resp_valid;
        if (imem_resp_valid && pend && cnt == 0) pend = 0;
        else if (pend) cnt--;
        if (o_hs) begin
            pend      = 1;
            pend_addr = imem_req_addr;
            cnt       = $urandom_range(dly_max, dly_min) - 1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        pend = 0;
        stall = 0;
        redirect_valid = 0;
        imem_req_ready = 1;
        instr_ready = 1;
        imem_resp_valid = 0;
        rdy_rand = 0;
        stray_en = 0;
        dly_min = 1;
        dly_max = 1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #3;
        n_checks++; if (pc_current !== RV) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc_current, RV); end
        n_checks++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        n_checks++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
        n_checks++; if (instr_data !== 32'h0) begin n_err++; $display("FAIL reset_instr_data: got %h want 0", instr_data); end
        n_checks++; if (instr_pc !== 32'h0) begin n_err++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
        n_checks++; if (misaligned_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", misaligned_fault); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        redirect_valid = 1;
        redirect_target = 32'h102;
        step();
        redirect_valid = 0;
        n_checks++; if (o_fault !== 1'b0) begin n_err++; $display("FAIL boot_fault: got %b want 0", o_fault); end
        n_checks++; if (o_req_valid !== 1'b0) begin n_err++; $display("FAIL boot_req: got %b want 0", o_req_valid); end
        n_checks++; if (pc_current !== RV) begin n_err++; $display("FAIL boot_redirect_pc: got %h want %h", pc_current, RV); end
    endtask

    task automatic test_free_run();
        int hs_at = -1;
        int v_at = -1;
        logic [31:0] got[$];
        do_reset();
        n_checks++; if (pc_current !== 32'h0) begin n_err++; $display("FAIL fr_pc0: got %h want 0", pc_current); end
        step();
        n_checks++; if (o_pc_next !== 32'h4) begin n_err++; $display("FAIL fr_pc_next0: got %h want 4", o_pc_next); end
        n_checks++; if (o_req_valid !== 1'b0) begin n_err++; $display("FAIL fr_boot_req: got %b want 0", o_req_valid); end
        for (int i = 1; i < 40 && got.size() < 3; i++) begin
            step();
            if (o_hs && hs_at < 0) begin
                hs_at = i;
                n_checks++; if (pc_current !== 32'h4) begin n_err++; $display("FAIL fr_pc_after_hs: got %h want 4", pc_current); end
                n_checks++; if (pc_next !== 32'h8) begin n_err++; $display("FAIL fr_next_after_hs: got %h want 8", pc_next); end
            end
            if (o_instr_valid && v_at < 0) v_at = i;
            if (o_acc) begin
                n_checks++; if (o_instr_data !== instr_of(o_instr_pc)) begin n_err++; $display("FAIL fr_data: got %h want %h", o_instr_data, instr_of(o_instr_pc)); end
                got.push_back(o_instr_pc);
            end
        end
        n_checks++;
        if (got.size() != 3) begin
            n_err++; $display("FAIL fr_count: got %0d want 3", got.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++; if (got[k] !== 32'(4 * k)) begin n_err++; $display("FAIL fr_seq%0d: got %h want %h", k, got[k], 32'(4 * k)); end
            end
        end
        n_checks++; if (v_at - hs_at != 2) begin n_err++; $display("FAIL fr_latency: got %0d want 2", v_at - hs_at); end
    endtask

    task automatic test_redirect_wait();
        bit found = 0;
        bit seen8 = 0;
        bit got_acc = 0;
        bit got_hs = 0;
        do_reset();
        dly_min = 3;
        dly_max = 3;
        for (int i = 0; i < 80 && !found; i++) begin
            step();
            if (o_hs && o_req_addr == 32'h8) found = 1;
        end
        n_checks++; if (!found) begin n_err++; $display("FAIL rw_reach8: got 0 want 1"); end
        redirect_valid = 1;
        redirect_target = 32'h100;
        step();
        redirect_valid = 0;
        n_checks++; if (o_pc_next !== 32'h100) begin n_err++; $display("FAIL rw_pc_next: got %h want 100", o_pc_next); end
        for (int i = 0; i < 40 && !got_acc; i++) begin
            step();
            if (o_hs && !got_hs) begin
                got_hs = 1;
                n_checks++; if (o_req_addr !== 32'h100) begin n_err++; $display("FAIL rw_req_addr: got %h want 100", o_req_addr); end
            end
            if (o_acc) begin
                got_acc = 1;
                if (o_instr_pc == 32'h8) seen8 = 1;
                n_checks++; if (o_instr_pc !== 32'h100) begin n_err++; $display("FAIL rw_instr_pc: got %h want 100", o_instr_pc); end
            end
        end
        n_checks++; if (seen8 || !got_acc) begin n_err++; $display("FAIL rw_stale: seen8=%b acc=%b want 0/1", seen8, got_acc); end
    endtask

    task automatic test_misaligned();
        do_reset();
        step();
        redirect_valid = 1;
        redirect_target = 32'h102;
        step();
        redirect_valid = 0;
        n_checks++; if (o_fault !== 1'b1) begin n_err++; $display("FAIL mis_fault: got %b want 1", o_fault); end
        n_checks++; if (o_pc_next !== TV) begin n_err++; $display("FAIL mis_pc_next: got %h want %h", o_pc_next, TV); end
        n_checks++; if (o_req_valid !== 1'b0) begin n_err++; $display("FAIL mis_req: got %b want 0", o_req_valid); end
        n_checks++; if (pc_current !== TV) begin n_err++; $display("FAIL mis_pc: got %h want %h", pc_current, TV); end
        step();
        n_checks++; if (o_fault !== 1'b0) begin n_err++; $display("FAIL mis_pulse: got %b want 0", o_fault); end
        n_checks++; if (!(o_hs && o_req_addr === 32'h10)) begin n_err++; $display("FAIL mis_req_addr: got %h/%b want 10/1", o_req_addr, o_hs); end
        n_checks++; if (pc_next !== 32'h18 || pc_current !== 32'h14) begin n_err++; $display("FAIL mis_follow: got %h want 14", pc_current); end
    endtask

    task automatic test_stall();
        do_reset();
        step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (o_req_valid !== 1'b0) begin n_err++; $display("FAIL st_req%0d: got %b want 0", i, o_req_valid); end
            n_checks++; if (pc_current !== 32'h0) begin n_err++; $display("FAIL st_pc%0d: got %h want 0", i, pc_current); end
        end
        stall = 0;
        step();
        n_checks++; if (!(o_hs && o_req_addr === 32'h0)) begin n_err++; $display("FAIL st_release: got %h/%b want 0/1", o_req_addr, o_hs); end
    endtask

    task automatic test_hold();
        bit found = 0;
        logic [31:0] d, p;
        do_reset();
        instr_ready = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (o_instr_valid) found = 1;
        end
        d = o_instr_data;
        p = o_instr_pc;
        n_checks++; if (!found || p !== 32'h0 || d !== instr_of(32'h0)) begin n_err++; $display("FAIL hd_first: got %h/%h want 0/%h", p, d, instr_of(32'h0)); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (o_instr_valid !== 1'b1 || o_instr_data !== d || o_instr_pc !== p || o_req_valid !== 1'b0) begin
                n_err++; $display("FAIL hd_stable%0d: got v=%b d=%h pc=%h req=%b want 1/%h/%h/0", i, o_instr_valid, o_instr_data, o_instr_pc, o_req_valid, d, p);
            end
        end
        instr_ready = 1;
        redirect_valid = 1;
        redirect_target = 32'h200;
        step();
        redirect_valid = 0;
        instr_ready = 0;
        n_checks++; if (o_instr_valid !== 1'b0 || o_acc !== 1'b0) begin n_err++; $display("FAIL hd_redirect: got v=%b want 0", o_instr_valid); end
        step();
        n_checks++; if (!(o_hs && o_req_addr === 32'h200)) begin n_err++; $display("FAIL hd_next_req: got %h/%b want 200/1", o_req_addr, o_hs); end
    endtask

    task automatic test_reset_mid_wait();
        int nhs = 0;
        bit got_acc = 0;
        do_reset();
        dly_min = 4;
        dly_max = 4;
        for (int i = 0; i < 60 && nhs < 2; i++) begin
            step();
            if (o_hs) nhs++;
        end
        step();
        n_checks++; if (pc_current !== 32'h8 || instr_data !== instr_of(32'h0)) begin n_err++; $display("FAIL rm_pre: got %h/%h want 8/%h", pc_current, instr_data, instr_of(32'h0)); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (pc_current !== RV || instr_valid !== 1'b0 || imem_req_valid !== 1'b0 || instr_data !== 32'h0 || instr_pc !== 32'h0 || misaligned_fault !== 1'b0) begin
            n_err++; $display("FAIL rm_async: got pc=%h v=%b req=%b d=%h ipc=%h want %h/0/0/0/0", pc_current, instr_valid, imem_req_valid, instr_data, instr_pc, RV);
        end
        step();
        reset_n = 1'b1;
        dly_min = 1;
        dly_max = 1;
        for (int i = 0; i < 20 && !got_acc; i++) begin
            step();
            if (o_acc) begin
                got_acc = 1;
                n_checks++; if (o_instr_pc !== 32'h0 || o_instr_data !== instr_of(32'h0)) begin n_err++; $display("FAIL rm_restart: got %h/%h want 0/%h", o_instr_pc, o_instr_data, instr_of(32'h0)); end
            end
        end
        n_checks++; if (!got_acc) begin n_err++; $display("FAIL rm_timeout: got 0 want 1"); end
    endtask

    task automatic test_wrap();
        int st = 0;
        do_reset();
        step();
        redirect_valid = 1;
        redirect_target = 32'hFFFF_FFFC;
        step();
        redirect_valid = 0;
        #1;
        n_checks++; if (pc_current !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wr_pc: got %h want fffffffc", pc_current); end
        n_checks++; if (pc_next !== 32'h0) begin n_err++; $display("FAIL wr_pc_next: got %h want 0", pc_next); end
        for (int i = 0; i < 40 && st < 2; i++) begin
            step();
            if (o_hs && st == 0) begin
                st = 1;
                n_checks++; if (o_req_addr !== 32'hFFFF_FFFC || pc_current !== 32'h0) begin n_err++; $display("FAIL wr_first: got %h pc=%h want fffffffc/0", o_req_addr, pc_current); end
            end else if (o_hs && st == 1) begin
                st = 2;
                n_checks++; if (o_req_addr !== 32'h0) begin n_err++; $display("FAIL wr_second: got %h want 0", o_req_addr); end
            end
        end
        n_checks++; if (st != 2) begin n_err++; $display("FAIL wr_timeout: got %0d want 2", st); end
    endtask

    task automatic test_random();
        logic [31:0] m_pc, exp_pc, tgt, newpc;
        int n_acc = 0;
        bit pb;
        do_reset();
        rdy_rand = 1;
        stray_en = 1;
        dly_min = 1;
        dly_max = 3;
        m_pc = RV;
        exp_pc = RV;
        for (int i = 0; i < 2000; i++) begin
            stall = ($urandom_range(3) == 0);
            instr_ready = 1'($urandom_range(1));
            redirect_valid = (i > 0) && ($urandom_range(11) == 0);
            tgt = $urandom;
            if ($urandom_range(3) == 0) tgt[1:0] = 2'($urandom_range(3, 1));
            else tgt[1:0] = 2'b00;
            redirect_target = tgt;
            newpc = (tgt % 4 != 0) ? TV : tgt;
            pb = pend;
            n_checks++; if (pc_current !== m_pc) begin n_err++; $display("FAIL rnd_pc@%0d: got %h want %h", i, pc_current, m_pc); end
            step();
            n_checks++; if (o_pc_next !== (redirect_valid ? newpc : m_pc + 32'd4)) begin n_err++; $display("FAIL rnd_pc_next@%0d: got %h want %h", i, o_pc_next, redirect_valid ? newpc : m_pc + 32'd4); end
            n_checks++; if (o_fault !== (redirect_valid && tgt % 4 != 0)) begin n_err++; $display("FAIL rnd_fault@%0d: got %b", i, o_fault); end
            if (o_req_valid) begin
                n_checks++; if (pb || stall || redirect_valid) begin n_err++; $display("FAIL rnd_req@%0d: got 1 want 0 (pend=%b st=%b rd=%b)", i, pb, stall, redirect_valid); end
            end
            if (o_hs) begin
                n_checks++; if (o_req_addr !== m_pc) begin n_err++; $display("FAIL rnd_addr@%0d: got %h want %h", i, o_req_addr, m_pc); end
            end
            if (o_instr_valid) begin
                n_checks++; if (redirect_valid) begin n_err++; $display("FAIL rnd_mask@%0d: got 1 want 0", i); end
            end
            if (o_acc) begin
                n_acc++;
                n_checks++; if (o_instr_pc !== exp_pc || o_instr_data !== instr_of(exp_pc)) begin n_err++; $display("FAIL rnd_instr@%0d: got %h/%h want %h/%h", i, o_instr_pc, o_instr_data, exp_pc, instr_of(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) begin
                m_pc = newpc;
                exp_pc = newpc;
            end else if (o_hs) begin
                m_pc = m_pc + 32'd4;
            end
        end
        n_checks++; if (n_acc < 100) begin n_err++; $display("FAIL rnd_progress: got %0d want >=100", n_acc); end
        rdy_rand = 0;
        stray_en = 0;
        stall = 0;
        redirect_valid = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_free_run();
        test_redirect_wait();
        test_misaligned();
        test_stall();
        test_hold();
        test_reset_mid_wait();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
